// File: rtl/pc_gen_bp_pkg.sv
// Shared configuration for the IF-stage PC generator: address defaults,
// stall-vector bit assignment, BTB sizing defaults and 2-bit counter encodings.
package pc_gen_bp_pkg;

   localparam int                 AddrLen         = 32;
   localparam logic [AddrLen-1:0] ZERO_WORD       = '0;

   localparam int                 STALL_W         = 6;
   localparam int                 STALL_PC        = 0;

   localparam int                 BTB_ENTRIES_DEF = 16;
   localparam int                 INST_BYTES_DEF  = 4;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   function automatic ctr_e ctr_train(input ctr_e c, input logic taken);
      ctr_e r;
      r = c;
      case (c)
         SNT:     r = taken ? WNT : SNT;
         WNT:     r = taken ? WT  : SNT;
         WT:      r = taken ? ST  : WNT;
         ST:      r = taken ? ST  : WT;
         default: r = c;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pc_gen_bp_btb.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters.
// Combinational lookup on the fetch PC, single training port written at the clock edge.
module pc_btb
   import pc_gen_bp_pkg::*;
#(
   parameter int ADDR_W      = AddrLen,
   parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
   parameter int INST_BYTES  = INST_BYTES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              lk_hit,
   output logic              lk_taken,
   output logic [ADDR_W-1:0] lk_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken
);

   localparam int OFS   = $clog2(INST_BYTES);
   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_W - OFS - IDX;

   logic [BTB_ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [ADDR_W-1:0]      target_q [BTB_ENTRIES];
   ctr_e                   ctr_q    [BTB_ENTRIES];

   logic [IDX-1:0]   lk_idx, upd_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;
   logic [1:0]       lk_ctr;
   logic             upd_hit;

   assign lk_idx  = lk_pc[OFS+IDX-1:OFS];
   assign lk_tag  = lk_pc[ADDR_W-1:OFS+IDX];
   assign upd_idx = upd_pc[OFS+IDX-1:OFS];
   assign upd_tag = upd_pc[ADDR_W-1:OFS+IDX];

   generate
      if (OFS > 0) begin : g_ofs
         logic unused_ofs;
         assign unused_ofs = ^{lk_pc[OFS-1:0], upd_pc[OFS-1:0]};
      end
   endgenerate

   always_comb begin
      lk_ctr    = ctr_q[lk_idx];
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_taken  = lk_hit && lk_ctr[1];
      lk_target = lk_taken ? target_q[lk_idx] : lk_pc + ADDR_W'(INST_BYTES);
   end

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   always_comb begin
      valid_d = valid_q;
      if (upd_valid && !upd_hit && upd_taken) begin
         valid_d[upd_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload has no reset: any write landing during reset hits an entry whose valid bit is held clear.
   always_ff @(posedge clk) begin
      if (upd_valid) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= ctr_train(ctr_q[upd_idx], upd_taken);
            if (upd_taken) begin
               target_q[upd_idx] <= upd_target;
            end
         end else if (upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= WT;
         end
      end
   end

endmodule

// File: rtl/pc_gen_bp.sv
// IF-stage program counter: redirect / stall / predicted-next mux around the PC register,
// with prediction supplied by the BTB.
module pc_gen_bp
   import pc_gen_bp_pkg::*;
#(
   parameter int                ADDR_W      = AddrLen,
   parameter int                BTB_ENTRIES = BTB_ENTRIES_DEF,
   parameter int                INST_BYTES  = INST_BYTES_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(ZERO_WORD)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               jump_flag,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic               upd_valid,
   input  logic [ADDR_W-1:0]  upd_pc,
   input  logic [ADDR_W-1:0]  upd_target,
   input  logic               upd_taken,
   output logic [ADDR_W-1:0]  pc,
   output logic               pred_taken,
   output logic [ADDR_W-1:0]  pred_target
);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  btb_target;
   logic               btb_taken;
   logic               unused_btb_hit;
   logic [STALL_W-1:0] unused_stall;

   assign unused_stall = stall;

   pc_btb #(
      .ADDR_W      (ADDR_W),
      .BTB_ENTRIES (BTB_ENTRIES),
      .INST_BYTES  (INST_BYTES)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .lk_pc      (pc_q),
      .lk_hit     (unused_btb_hit),
      .lk_taken   (btb_taken),
      .lk_target  (btb_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken)
   );

   // A redirect from ex overrides the stall: the wrong-path fetch must be abandoned regardless.
   always_comb begin
      pc_d = pc_q;
      if (jump_flag) begin
         pc_d = jump_addr;
      end else if (!stall[STALL_PC]) begin
         pc_d = btb_target;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc          = pc_q;
   assign pred_taken  = btb_taken;
   assign pred_target = btb_target;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Self-checking bench for pc_gen_bp: directed scenarios plus random traffic,
// scored against a behavioural BTB/PC model through an expected-output queue.
module tb_pc_gen_bp;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;

   always #5 clk = ~clk;

   pc_gen_bp dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .jump_flag   (jump_flag),
      .jump_addr   (jump_addr),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken),
      .pc          (pc),
      .pred_taken  (pred_taken),
      .pred_target (pred_target)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // {pc, pred_taken, pred_target} expected for the cycle in which it is pushed
   logic [64:0] exp_q[$];
   logic [64:0] mon_e;

   // reference model: 16-entry table keyed by (pc/4)%16, tag is pc/64
   bit          m_valid [16];
   logic [31:0] m_bpc   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic [31:0] m_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_index(input logic [31:0] a);
      return int'((a / 4) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      int i;
      i = m_index(a);
      return m_valid[i] && ((m_bpc[i] / 64) == (a / 64));
   endfunction

   function automatic bit m_taken(input logic [31:0] a);
      return m_hit(a) && (m_ctr[m_index(a)] >= 2);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] a);
      logic [31:0] seq;
      seq = a + 32'd4;
      return m_taken(a) ? m_tgt[m_index(a)] : seq;
   endfunction

   task automatic m_train(input logic [31:0] up, input logic [31:0] ut, input logic tk);
      int i;
      i = m_index(up);
      if (m_hit(up)) begin
         if (tk) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = ut;
         end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (tk) begin
         m_valid[i] = 1'b1;
         m_bpc[i]   = up;
         m_tgt[i]   = ut;
         m_ctr[i]   = 2;
      end
   endtask

   task automatic m_reset();
      m_pc = 32'h0;
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   task automatic drive_idle();
      stall      = 6'h0;
      jump_flag  = 1'b0;
      jump_addr  = 32'h0;
      upd_valid  = 1'b0;
      upd_pc     = 32'h0;
      upd_target = 32'h0;
      upd_taken  = 1'b0;
   endtask

   // Called between edges: queue this cycle's expected outputs, drive, clock, advance model.
   task automatic step(input logic [5:0] st, input logic jf, input logic [31:0] ja,
                       input logic uv, input logic [31:0] up, input logic [31:0] ut,
                       input logic tk);
      logic [31:0] nxt;
      logic        tkn;
      tkn = m_taken(m_pc);
      nxt = m_next(m_pc);
      exp_q.push_back({m_pc, tkn, nxt});
      stall      = st;
      jump_flag  = jf;
      jump_addr  = ja;
      upd_valid  = uv;
      upd_pc     = up;
      upd_target = ut;
      upd_taken  = tk;
      @(posedge clk);
      if (jf) m_pc = ja;
      else if (!st[0]) m_pc = nxt;
      if (uv) m_train(up, ut, tk);
      #1;
      drive_idle();
   endtask

   task automatic idle();
      step(6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic jump(input logic [31:0] a);
      step(6'h0, 1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic train(input logic [31:0] up, input logic [31:0] ut, input logic tk);
      step(6'h0, 1'b0, 32'h0, 1'b1, up, ut, tk);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("sb_pc", pc, mon_e[64:33]);
         check("sb_pred_taken", 32'(pred_taken), 32'(mon_e[32]));
         check("sb_pred_target", pred_target, mon_e[31:0]);
      end
   end

   initial begin
      logic [5:0]  r_st;
      logic [31:0] r_ja;
      rst = 1'b0;
      drive_idle();
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", pc, 32'h0);
      check("reset_pred_taken", 32'(pred_taken), 32'h0);
      #2;
      rst = 1'b1;

      // free-running from reset with an empty BTB
      repeat (4) idle();
      check("seq_pc16", pc, 32'h10);

      // training while fetching the same pc is not bypassed
      train(32'h10, 32'h80, 1'b1);
      check("no_bypass", pc, 32'h14);
      jump(32'h0);
      repeat (4) idle();
      check("hit_taken", 32'(pred_taken), 32'h1);
      check("hit_target", pred_target, 32'h80);
      idle();
      check("follow_pred", pc, 32'h80);

      // counter 10 -> 01 -> 00, then T x4 saturates at 11, one NT leaves it taken
      train(32'h10, 32'h0, 1'b0);
      train(32'h10, 32'h0, 1'b0);
      jump(32'h10);
      check("nt_taken", 32'(pred_taken), 32'h0);
      check("nt_target", pred_target, 32'h14);
      idle();
      check("nt_fallthru", pc, 32'h14);
      repeat (4) train(32'h10, 32'h80, 1'b1);
      train(32'h10, 32'h0, 1'b0);
      jump(32'h10);
      check("sat_taken", 32'(pred_taken), 32'h1);

      // stall holds, redirect beats stall, other stall bits ignored
      jump(32'h20);
      step(6'h01, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("stall_hold", pc, 32'h20);
      step(6'h01, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);
      check("jump_in_stall", pc, 32'h200);
      step(6'h01, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("stall_hold2", pc, 32'h200);
      step(6'h3e, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("upper_stall_ignored", pc, 32'h204);

      // alias: 0x50 overwrites 0x10's entry
      train(32'h50, 32'h90, 1'b1);
      jump(32'h10);
      check("alias_miss", 32'(pred_taken), 32'h0);
      check("alias_miss_tgt", pred_target, 32'h14);
      jump(32'h50);
      check("alias_hit", 32'(pred_taken), 32'h1);
      check("alias_hit_tgt", pred_target, 32'h90);

      // wrap and unaligned redirect
      jump(32'hffff_fffc);
      idle();
      check("wrap", pc, 32'h0);
      jump(32'h102);
      check("unaligned_pc", pc, 32'h102);
      check("unaligned_tgt", pred_target, 32'h106);

      // asynchronous reset between edges, with pending jump/training discarded
      train(32'h48, 32'h300, 1'b1);
      jump(32'h48);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_pc", pc, 32'h0);
      m_reset();
      jump_flag  = 1'b1;
      jump_addr  = 32'h300;
      upd_valid  = 1'b1;
      upd_pc     = 32'h0;
      upd_target = 32'h400;
      upd_taken  = 1'b1;
      @(posedge clk);
      #3;
      drive_idle();
      rst = 1'b1;
      idle();
      check("restart_pc4", pc, 32'h4);
      jump(32'h48);
      check("cleared_48", 32'(pred_taken), 32'h0);
      jump(32'h50);
      check("cleared_50", 32'(pred_taken), 32'h0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         r_st    = 6'($urandom_range(0, 63));
         r_st[0] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) r_ja = 32'hffff_fff0 + 32'(4 * $urandom_range(0, 3));
         else r_ja = 32'(4 * $urandom_range(0, 47));
         if ($urandom_range(0, 15) == 0) r_ja = r_ja + 32'($urandom_range(1, 3));
         step(r_st, ($urandom_range(0, 7) == 0), r_ja,
              1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 47)),
              32'(4 * $urandom_range(0, 63)), ($urandom_range(0, 2) != 0));
      end

      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen_bp.md
Name: pc_gen_bp

Overview:
Parametrised program-counter generator for the IF stage, with a direct-mapped branch target buffer (BTB) and a 2-bit saturating-counter direction predictor.
- Each cycle it presents the fetch PC and a next-PC prediction to if.v.
- It accepts redirects from ex.v on misprediction.
- It accepts BTB training updates from ex.v for every resolved control-flow instruction.
- It honours the ctrl.v stall vector.

Parameters:
ADDR_W, 32, width of pc and every address port.
BTB_ENTRIES, 16, BTB entry count; power of 2, minimum 2.
INST_BYTES, 4, sequential increment; power of 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
stall  in  6  pipeline stall vector from ctrl.v; bit 0 freezes the PC.
jump_flag  in  1  redirect request from ex.v.
jump_addr  in  ADDR_W  redirect target.
upd_valid  in  1  BTB training strobe from ex.v.
upd_pc  in  ADDR_W  PC of the resolved branch or jump.
upd_target  in  ADDR_W  resolved target.
upd_taken  in  1  resolved direction.
pc  out  ADDR_W  current fetch PC, registered.
pred_taken  out  1  prediction for the instruction at pc; combinational from pc and BTB state.
pred_target  out  ADDR_W  predicted next PC: the BTB target, or pc+INST_BYTES.

Behaviour:
Index and tag fields:
- OFS = log2(INST_BYTES); IDX = log2(BTB_ENTRIES).
- index = pc[OFS+IDX-1 : OFS]; tag = pc[ADDR_W-1 : OFS+IDX].

Entry contents:
- Each entry holds valid, tag, target (ADDR_W) and a 2-bit counter.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Lookup (combinational on registered pc):
- hit = valid & (tag match).
- pred_taken = hit & counter[1].
- pred_target = pred_taken ? entry target : pc + INST_BYTES. The add wraps modulo 2^ADDR_W.

Next-PC update at each rising edge, in priority order:
1. rst low: asynchronous. pc = RESET_PC; all valid bits = 0. Targets, tags and counters are don't-care.
2. jump_flag = 1: pc <= jump_addr. Applied even when stall[0] = 1.
3. stall[0] = 1: pc holds.
4. Otherwise: pc <= pred_target.

Latency:
- Redirect: pc equals jump_addr one cycle after jump_flag is sampled.
- First fetch: the first edge after reset release advances pc from RESET_PC.

BTB training at a rising edge when upd_valid = 1. Training is independent of stall and jump_flag.
- Hit on upd_pc's entry with upd_taken = 1: counter saturating +1 (11 stays 11); target <= upd_target.
- Hit on upd_pc's entry with upd_taken = 0: counter saturating -1 (00 stays 00); target unchanged.
- Miss with upd_taken = 1: allocate or overwrite the entry. valid = 1, tag, target = upd_target, counter = 10.
- Miss with upd_taken = 0: no change.

Simultaneous training and lookup on the same index:
- Lookup uses pre-edge contents; the write is visible from the next cycle.
- There is no bypass.

Reset mid-operation:
- Asynchronous clear takes effect immediately, regardless of clk.
- A pending upd_valid or jump_flag in that cycle is discarded.

Other boundary conditions:
- Unaligned jump_addr is passed through unchanged; alignment checking belongs to ex.v.
- pc near 2^ADDR_W wraps to 0 on a sequential increment.

Decomposition:
Shared config header additions:
- Counter encodings SNT/WNT/WT/ST.
- STALL_PC bit index (0).
- BTB width defaults.
- Existing AddrLen and ZERO_WORD are reused for the defaults.

Sub-module pc_btb, covering storage, lookup and training:
- Ports: clk, rst, lookup pc, hit/taken/target outputs, update port.
- pc_gen_bp is the next-PC mux and PC register around it.

Test Plan:
1. Reset then 4 free-running cycles, BTB empty, ADDR_W = 32 -> pc sequence 0, 4, 8, 12, 16; pred_taken = 0 throughout.
2. Train upd_pc=0x10, upd_target=0x80, upd_taken=1 once, then run from 0 -> at pc=0x10, pred_taken = 1 and pred_target = 0x80; next pc = 0x80.
3. Train the same branch NT twice after one T (10 -> 01 -> 00) -> at pc=0x10, pred_taken = 0 and the next pc is 0x14. Train T four more times -> counter saturates at 11.
4. stall[0] = 1 for 3 cycles at pc=0x20, with jump_flag=1, jump_addr=0x200 in the 2nd stalled cycle -> pc stays 0x20, then becomes 0x200 and holds while the stall persists.
5. Alias: train upd_pc=0x10 and then upd_pc=0x50 (same index, BTB_ENTRIES = 16), both taken -> pc=0x10 misses and falls through to 0x14; pc=0x50 hits.
6. Assert rst low between clock edges with pc=0x48 and a trained BTB -> pc is 0 immediately. After release, all lookups miss and the sequence restarts at 0, 4.
